// File: rtl/quantum_meas_pkg.sv
// Shared types and constants for the qubit measurement samplers.
//   Q16_W        : width of a Q15.16 word
//   ONE_Q16      : 1.0 in Q15.16
//   meas_state_t : measurement sequencer states
package quantum_meas_pkg;

  localparam int Q16_W = 32;
  localparam logic [Q16_W-1:0] ONE_Q16 = 32'h0001_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } meas_state_t;

endpackage

// File: rtl/q16_prob_compare.sv
// Combinational Monte-Carlo outcome decision for one shot.
// Ports:
//   prob0   in  Q16_W  P(|0>) in signed Q15.16
//   rand_in in  Q16_W  uniform random word in [0,1); only bits [15:0] matter
//   outcome out 1      0 when rand_in < clamped probability, else 1
//   clamped out 1      prob0 was outside [0,1.0] and had to be clamped
module q16_prob_compare
  import quantum_meas_pkg::*;
(
  input  logic [Q16_W-1:0] prob0,
  input  logic [Q16_W-1:0] rand_in,
  output logic             outcome,
  output logic             clamped
);

  logic [16:0] p;
  logic        unused_rand_hi;

  // Upper random bits are defined to be zero and are deliberately ignored.
  assign unused_rand_hi = ^rand_in[Q16_W-1:16];

  // Negative probabilities clamp to 0 (always outcome 1); anything at or above
  // 1.0 clamps to 1.0 (always outcome 0, since rand_in < 1.0). Exactly 1.0 is
  // in range, so it does not count as clamped.
  always_comb begin
    p       = {1'b0, prob0[15:0]};
    clamped = 1'b0;
    if (prob0[Q16_W-1]) begin
      p       = '0;
      clamped = 1'b1;
    end else if (prob0 >= ONE_Q16) begin
      p       = ONE_Q16[16:0];
      clamped = (prob0 != ONE_Q16);
    end
    outcome = ({1'b0, rand_in[15:0]} < p) ? 1'b0 : 1'b1;
  end

endmodule

// File: rtl/qubit_measure_sampler.sv
// Monte-Carlo measurement stage for one qubit: runs N shots against the LFSR
// random stream and counts |0> and |1> outcomes for controller readback.
// Optional feature macro: MEAS_RANGE_ERR_EN adds the range_err output.
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   start             one-cycle run request, accepted only when idle
//   prob0             P(|0>) in Q15.16, latched at acceptance
//   shots             number of shots, latched at acceptance
//   rand_in           LFSR word in [0,1), used only on sample cycles
//   busy              high from the cycle after acceptance through DONE
//   done              one-cycle completion pulse, counters final
//   result_bit        outcome of the most recent shot
//   count_zeros/ones  outcome counters
//   range_err         (MEAS_RANGE_ERR_EN) prob0 of the current run was clamped
module qubit_measure_sampler
  import quantum_meas_pkg::*;
#(
  parameter int SAMPLE_GAP = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [Q16_W-1:0] prob0,
  input  logic [CNT_W-1:0] shots,
  input  logic [Q16_W-1:0] rand_in,
  output logic             busy,
  output logic             done,
  output logic             result_bit,
  output logic [CNT_W-1:0] count_zeros,
  output logic [CNT_W-1:0] count_ones
`ifdef MEAS_RANGE_ERR_EN
  ,
  output logic             range_err
`endif
);

  localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SAMPLE_GAP - 1);

  meas_state_t      state_q, state_d;
  logic [Q16_W-1:0] prob_q, prob_d;
  logic [CNT_W-1:0] shots_left_q, shots_left_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] zeros_q, zeros_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic             result_q, result_d;
  logic             outcome_w;
  logic             clamped_w;

  q16_prob_compare u_compare (
    .prob0   (prob_q),
    .rand_in (rand_in),
    .outcome (outcome_w),
    .clamped (clamped_w)
  );

  // Sequencer: a run waits SAMPLE_GAP-1 cycles between samples so that shot k
  // lands exactly k*SAMPLE_GAP cycles after acceptance. WAIT leaves when the
  // decremented gap count reaches zero; a gap of one skips WAIT entirely.
  always_comb begin
    state_d      = state_q;
    prob_d       = prob_q;
    shots_left_d = shots_left_q;
    gap_cnt_d    = gap_cnt_q;
    zeros_d      = zeros_q;
    ones_d       = ones_q;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          prob_d       = prob0;
          shots_left_d = shots;
          zeros_d      = '0;
          ones_d       = '0;
          gap_cnt_d    = GAP_RELOAD;
          if (shots == '0) begin
            state_d = DONE;
          end else if (SAMPLE_GAP == 1) begin
            state_d = SAMPLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        result_d = outcome_w;
        if (outcome_w) begin
          ones_d = ones_q + CNT_W'(1);
        end else begin
          zeros_d = zeros_q + CNT_W'(1);
        end
        shots_left_d = shots_left_q - CNT_W'(1);
        gap_cnt_d    = GAP_RELOAD;
        if (shots_left_q == CNT_W'(1)) begin
          state_d = DONE;
        end else if (SAMPLE_GAP == 1) begin
          state_d = SAMPLE;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run with no done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prob_q       <= '0;
      shots_left_q <= '0;
      gap_cnt_q    <= '0;
      zeros_q      <= '0;
      ones_q       <= '0;
      result_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prob_q       <= prob_d;
      shots_left_q <= shots_left_d;
      gap_cnt_q    <= gap_cnt_d;
      zeros_q      <= zeros_d;
      ones_q       <= ones_d;
      result_q     <= result_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign result_bit  = result_q;
  assign count_zeros = zeros_q;
  assign count_ones  = ones_q;

`ifdef MEAS_RANGE_ERR_EN
  // prob_q only changes at acceptance and resets to 0, so this flag is a
  // function of registered state and holds until the next accepted start.
  assign range_err = clamped_w;
`else
  logic unused_clamped;
  assign unused_clamped = clamped_w;
`endif

endmodule

// File: tb/tb_qubit_measure_sampler.sv
// Self-checking bench for qubit_measure_sampler with randomized LFSR words
// and a time-based behavioural model of a measurement run.
module tb_qubit_measure_sampler;

  localparam int G = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   prob0 = '0;
  logic [CW-1:0] shots = '0;
  logic [31:0]   rand_in = '0;
  logic          busy, done, result_bit;
  logic [CW-1:0] count_zeros, count_ones;
`ifdef MEAS_RANGE_ERR_EN
  logic          range_err;
`endif

  int assert_cnt = 0;
  int fail_cnt = 0;
  int ecount = 0;
  bit check_en = 1'b0;
  logic [15:0] cur_prob_lo = '0;

  // Model of the observable run state.
  bit m_active = 0, m_busy = 0, m_done = 0, m_bit = 0, m_err = 0;
  int m_acc = 0, m_shots = 0, m_p = 0, m_zeros = 0, m_ones = 0;

  qubit_measure_sampler #(.SAMPLE_GAP(G), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .prob0       (prob0),
    .shots       (shots),
    .rand_in     (rand_in),
    .busy        (busy),
    .done        (done),
    .result_bit  (result_bit),
    .count_zeros (count_zeros),
    .count_ones  (count_ones)
`ifdef MEAS_RANGE_ERR_EN
    ,
    .range_err   (range_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  function automatic int clampProb(input logic [31:0] pr);
    if (pr[31]) return 0;
    if (pr > 32'h0001_0000) return 65536;
    return int'(pr);
  endfunction

  function automatic bit isAltered(input logic [31:0] pr);
    return pr[31] || (pr > 32'h0001_0000);
  endfunction

  // Run model: shot k is decided by rand_in at the edge k*G after acceptance;
  // the DONE cycle follows the last shot (or acceptance when shots is zero).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 0; m_busy <= 0; m_done <= 0; m_bit <= 0; m_err <= 0;
      m_zeros <= 0; m_ones <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1; m_busy <= 1; m_done <= (shots == 0);
        m_acc <= ecount + 1; m_shots <= int'(shots);
        m_p <= clampProb(prob0); m_err <= isAltered(prob0);
        m_zeros <= 0; m_ones <= 0;
      end
    end else if (m_done) begin
      m_active <= 0; m_busy <= 0; m_done <= 0;
    end else if (((ecount + 1 - m_acc) % G) == 0) begin
      if (int'(rand_in[15:0]) < m_p) begin
        m_zeros <= m_zeros + 1; m_bit <= 0;
      end else begin
        m_ones <= m_ones + 1; m_bit <= 1;
      end
      if ((ecount + 1 - m_acc) == m_shots * G) m_done <= 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, actual, expected, ecount);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    assert_cnt++;
    if (actual < lo || actual > hi) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Pulses start for one cycle; returns at the first cycle after acceptance.
  task automatic applyStimulus(input logic [31:0] p, input int n, output int acc);
    @(negedge clk);
    prob0 = p; shots = CW'(n); start = 1'b1;
    cur_prob_lo = p[15:0];
    @(negedge clk);
    start = 1'b0;
    acc = ecount;
  endtask

  // Returns the cycle number (relative to acceptance) in which done is high.
  task automatic waitDone(input int acc, input int budget, output int rel);
    rel = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        rel = ecount - acc + 1;
        return;
      end
      @(negedge clk);
    end
    checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Random LFSR stream, occasionally hitting the probability boundary exactly.
  initial begin
    forever begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0: rand_in = {16'h0, cur_prob_lo};
        1: rand_in = 32'($urandom_range(0, 64));
        default: rand_in = 32'($urandom_range(0, 65535));
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("busy", 32'(busy), 32'(m_busy));
        checkOutput("done", 32'(done), 32'(m_done));
        checkOutput("result_bit", 32'(result_bit), 32'(m_bit));
        checkOutput("count_zeros", 32'(count_zeros), 32'(m_zeros));
        checkOutput("count_ones", 32'(count_ones), 32'(m_ones));
`ifdef MEAS_RANGE_ERR_EN
        checkOutput("range_err", 32'(range_err), 32'(m_err));
`endif
      end
    end
  end

  initial begin
    int acc, rel, n;
    logic [31:0] p;
    bit seen_done;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_counts", 32'({count_zeros, count_ones}), 32'd0);
    reset_n = 1'b1;
    check_en = 1'b1;

    // p = 0.5 over 1000 shots.
    applyStimulus(32'h0000_8000, 1000, acc);
    waitDone(acc, 17000, rel);
    checkOutput("t1_done_cycle", 32'(rel), 32'd16001);
    checkOutput("t1_total", 32'(count_zeros) + 32'(count_ones), 32'd1000);
    checkRange("t1_ones", int'(count_ones), 450, 550);

    // p = 1.0 exactly: all zeros, not a clamp.
    applyStimulus(32'h0001_0000, 10, acc);
    waitDone(acc, 200, rel);
    checkOutput("t2_zeros", 32'(count_zeros), 32'd10);
    checkOutput("t2_ones", 32'(count_ones), 32'd0);
`ifdef MEAS_RANGE_ERR_EN
    checkOutput("t2_range_err", 32'(range_err), 32'd0);
`endif

    // Negative probability: all ones.
    applyStimulus(32'hFFFF_0000, 10, acc);
    waitDone(acc, 200, rel);
    checkOutput("t3_ones", 32'(count_ones), 32'd10);
    checkOutput("t3_zeros", 32'(count_zeros), 32'd0);
`ifdef MEAS_RANGE_ERR_EN
    checkOutput("t3_range_err", 32'(range_err), 32'd1);
`endif

    // Zero shots: done in the first cycle, idle in the second.
    @(negedge clk);
    applyStimulus(32'h0000_4000, 0, acc);
    checkOutput("t4_busy_t1", 32'(busy), 32'd1);
    checkOutput("t4_done_t1", 32'(done), 32'd1);
    checkOutput("t4_counts", 32'({count_zeros, count_ones}), 32'd0);
    @(negedge clk);
    checkOutput("t4_busy_t2", 32'(busy), 32'd0);

    // Second start during a run is ignored.
    @(negedge clk);
    applyStimulus(32'h0000_C000, 10, acc);
    while (ecount < acc + 4) @(negedge clk);
    prob0 = 32'h0; shots = CW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(acc, 300, rel);
    checkOutput("t5_done_cycle", 32'(rel), 32'd161);
    checkOutput("t5_total", 32'(count_zeros) + 32'(count_ones), 32'd10);

    // Reset after the third of ten shots aborts the run.
    @(negedge clk);
    applyStimulus(32'h0000_8000, 10, acc);
    while (ecount < acc + 3 * G) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_done", 32'(done), 32'd0);
    checkOutput("t6_result", 32'(result_bit), 32'd0);
    checkOutput("t6_counts", 32'({count_zeros, count_ones}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen_done = 0;
    repeat (200) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    checkOutput("t6_no_done", 32'(seen_done), 32'd0);
    applyStimulus(32'h0000_2000, 5, acc);
    waitDone(acc, 200, rel);
    checkOutput("t6_restart_cycle", 32'(rel), 32'd81);
    checkOutput("t6_restart_total", 32'(count_zeros) + 32'(count_ones), 32'd5);

    // Randomized runs across in-range, negative, over-range and tiny probabilities.
    for (int r = 0; r < 16; r++) begin
      case ($urandom_range(0, 3))
        0: p = 32'($urandom_range(0, 65536));
        1: p = 32'h8000_0000 | 32'($urandom);
        2: p = 32'h0001_0001 + 32'($urandom_range(0, 1000000));
        default: p = 32'($urandom_range(0, 64));
      endcase
      n = $urandom_range(0, 12);
      @(negedge clk);
      applyStimulus(p, n, acc);
      waitDone(acc, 300, rel);
      checkOutput("rnd_done_cycle", 32'(rel), 32'(n * G + 1));
      checkOutput("rnd_total", 32'(count_zeros) + 32'(count_ones), 32'(n));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
